// File: rtl/rx_tank_pos_deframer.sv
// Receive-side deframer for tank position frames: hunts for the 0xFF preamble,
// rebuilds the 10-bit X/Y positions and aborts on bad high bytes or inter-byte stalls.
module rx_tank_pos_deframer #(
  parameter int SYNC_LEN = 4,
  parameter int TIMEOUT  = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       pos_valid,
  output logic       frame_err,
  output logic       sync_lock
);

  localparam int FF_W   = (SYNC_LEN < 2) ? 1 : $clog2(SYNC_LEN + 1);
  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_X_LO = 3'd1,
    S_X_HI = 3'd2,
    S_Y_LO = 3'd3,
    S_Y_HI = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [FF_W-1:0]     ff_cnt_q, ff_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [9:0]          x_hold_q, x_hold_d;
  logic [7:0]          y_hold_q, y_hold_d;
  logic [9:0]          x_pos_q, x_pos_d;
  logic [9:0]          y_pos_q, y_pos_d;
  logic                pos_valid_q, pos_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                sync_lock_q, sync_lock_d;
  logic                hi_ok;
  logic                abort_hi;

  // A high byte carries only two payload bits; anything in [7:2] means a broken frame.
  assign hi_ok = (rx_data[7:2] == 6'd0);

  always_comb begin
    state_d     = state_q;
    ff_cnt_d    = ff_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    x_hold_d    = x_hold_q;
    y_hold_d    = y_hold_q;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    sync_lock_d = sync_lock_q;
    pos_valid_d = 1'b0;
    frame_err_d = 1'b0;
    abort_hi    = 1'b0;

    if (rx_done) begin
      idle_cnt_d = '0;
      case (state_q)
        S_HUNT: begin
          if (rx_data == 8'hFF) begin
            if (ff_cnt_q == FF_W'(SYNC_LEN - 1)) begin
              ff_cnt_d = '0;
              state_d  = S_X_LO;
            end else begin
              ff_cnt_d = ff_cnt_q + FF_W'(1);
            end
          end else begin
            ff_cnt_d = '0;
          end
        end
        S_X_LO: begin
          x_hold_d[7:0] = rx_data;
          state_d       = S_X_HI;
        end
        S_X_HI: begin
          if (hi_ok) begin
            x_hold_d[9:8] = rx_data[1:0];
            state_d       = S_Y_LO;
          end else begin
            abort_hi = 1'b1;
          end
        end
        S_Y_LO: begin
          y_hold_d = rx_data;
          state_d  = S_Y_HI;
        end
        S_Y_HI: begin
          if (hi_ok) begin
            x_pos_d     = x_hold_q;
            y_pos_d     = {rx_data[1:0], y_hold_q};
            pos_valid_d = 1'b1;
            sync_lock_d = 1'b1;
            state_d     = S_HUNT;
          end else begin
            abort_hi = 1'b1;
          end
        end
        default: begin
          state_d  = S_HUNT;
          ff_cnt_d = '0;
        end
      endcase

      // The offending 0xFF may be the first byte of the next preamble.
      if (abort_hi) begin
        frame_err_d = 1'b1;
        sync_lock_d = 1'b0;
        state_d     = S_HUNT;
        ff_cnt_d    = (rx_data == 8'hFF) ? FF_W'(1) : '0;
      end
    end else if (state_q != S_HUNT) begin
      if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
        frame_err_d = 1'b1;
        sync_lock_d = 1'b0;
        state_d     = S_HUNT;
        ff_cnt_d    = '0;
        idle_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      ff_cnt_q    <= '0;
      idle_cnt_q  <= '0;
      x_hold_q    <= '0;
      y_hold_q    <= '0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      pos_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      sync_lock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ff_cnt_q    <= ff_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      x_hold_q    <= x_hold_d;
      y_hold_q    <= y_hold_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      pos_valid_q <= pos_valid_d;
      frame_err_q <= frame_err_d;
      sync_lock_q <= sync_lock_d;
    end
  end

  assign x_pos     = x_pos_q;
  assign y_pos     = y_pos_q;
  assign pos_valid = pos_valid_q;
  assign frame_err = frame_err_q;
  assign sync_lock = sync_lock_q;

endmodule

// File: tb/tb_rx_tank_pos_deframer.sv
// Bench for rx_tank_pos_deframer: directed frame scenarios plus a randomized byte
// stream checked cycle by cycle against a queue-based frame model.
module tb_rx_tank_pos_deframer;

  localparam int SYNC_LEN = 4;
  localparam int TO       = 64;

  logic       clk;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       pos_valid;
  logic       frame_err;
  logic       sync_lock;

  int n_checks;
  int n_fail;

  rx_tank_pos_deframer #(.SYNC_LEN(SYNC_LEN), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .pos_valid (pos_valid),
    .frame_err (frame_err),
    .sync_lock (sync_lock)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: preamble run length, data bytes of the current frame, idle time
  int         m_ff_run;
  bit         m_in_frame;
  logic [7:0] m_data_q[$];
  int         m_idle;
  logic [9:0] m_x, m_y;
  logic       m_valid, m_err, m_lock;

  function void model_reset();
    m_ff_run   = 0;
    m_in_frame = 0;
    m_data_q.delete();
    m_idle     = 0;
    m_x        = '0;
    m_y        = '0;
    m_valid    = 0;
    m_err      = 0;
    m_lock     = 0;
  endfunction

  function void model_step(input logic r, input logic rd, input logic [7:0] d);
    m_valid = 0;
    m_err   = 0;
    if (r) begin
      model_reset();
    end else if (rd) begin
      m_idle = 0;
      if (!m_in_frame) begin
        if (d == 8'hFF) begin
          m_ff_run++;
          if (m_ff_run == SYNC_LEN) begin
            m_ff_run   = 0;
            m_in_frame = 1;
            m_data_q.delete();
          end
        end else begin
          m_ff_run = 0;
        end
      end else begin
        m_data_q.push_back(d);
        if ((m_data_q.size() == 2 || m_data_q.size() == 4) && (d > 8'd3)) begin
          m_err      = 1;
          m_lock     = 0;
          m_in_frame = 0;
          m_ff_run   = (d == 8'hFF) ? 1 : 0;
        end else if (m_data_q.size() == 4) begin
          m_x        = 10'(m_data_q[1]) * 10'd256 + 10'(m_data_q[0]);
          m_y        = 10'(m_data_q[3]) * 10'd256 + 10'(m_data_q[2]);
          m_valid    = 1;
          m_lock     = 1;
          m_in_frame = 0;
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == TO) begin
        m_err      = 1;
        m_lock     = 0;
        m_in_frame = 0;
        m_ff_run   = 0;
        m_idle     = 0;
      end
    end
  endfunction

  // driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic tick(input logic rd, input logic [7:0] d);
    rx_done = rd;
    rx_data = d;
    @(posedge clk);
    model_step(rst, rd, d);
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(1'b1, b);
    tick(1'b0, 8'h5A);
  endtask

  task automatic send_preamble();
    for (int i = 0; i < SYNC_LEN; i++) send_byte(8'hFF);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 8'h00);
    tick(1'b1, 8'hFF);
    n_checks += 5;
    if (x_pos !== 10'd0)     begin n_fail++; $display("FAIL reset_x: got %0d want 0", x_pos); end
    if (y_pos !== 10'd0)     begin n_fail++; $display("FAIL reset_y: got %0d want 0", y_pos); end
    if (pos_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %0b want 0", pos_valid); end
    if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %0b want 0", frame_err); end
    if (sync_lock !== 1'b0)  begin n_fail++; $display("FAIL reset_lock: got %0b want 0", sync_lock); end
    rst = 1'b0;
    tick(1'b0, 8'h00);
  endtask

  task automatic test_clean_frame();
    send_preamble();
    send_byte(8'h2C);
    send_byte(8'h01);
    send_byte(8'hE0);
    n_checks++;
    if (pos_valid !== 1'b0) begin n_fail++; $display("FAIL clean_early_valid: got %0b want 0", pos_valid); end
    tick(1'b1, 8'h01);
    n_checks += 4;
    if (pos_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %0b want 1", pos_valid); end
    if (x_pos !== 10'd300)  begin n_fail++; $display("FAIL clean_x: got %0d want 300", x_pos); end
    if (y_pos !== 10'd480)  begin n_fail++; $display("FAIL clean_y: got %0d want 480", y_pos); end
    if (sync_lock !== 1'b1) begin n_fail++; $display("FAIL clean_lock: got %0b want 1", sync_lock); end
    tick(1'b0, 8'h00);
    n_checks++;
    if (pos_valid !== 1'b0) begin n_fail++; $display("FAIL clean_valid_width: got %0b want 0", pos_valid); end
  endtask

  task automatic test_sync_as_data();
    send_preamble();
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h10);
    tick(1'b1, 8'h00);
    n_checks += 4;
    if (pos_valid !== 1'b1) begin n_fail++; $display("FAIL syncdata_valid: got %0b want 1", pos_valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL syncdata_err: got %0b want 0", frame_err); end
    if (x_pos !== 10'd255)  begin n_fail++; $display("FAIL syncdata_x: got %0d want 255", x_pos); end
    if (y_pos !== 10'd16)   begin n_fail++; $display("FAIL syncdata_y: got %0d want 16", y_pos); end
  endtask

  task automatic test_bad_high_byte();
    send_preamble();
    send_byte(8'h10);
    tick(1'b1, 8'h05);
    n_checks += 5;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL badhi_err: got %0b want 1", frame_err); end
    if (pos_valid !== 1'b0) begin n_fail++; $display("FAIL badhi_valid: got %0b want 0", pos_valid); end
    if (sync_lock !== 1'b0) begin n_fail++; $display("FAIL badhi_lock: got %0b want 0", sync_lock); end
    if (x_pos !== 10'd255)  begin n_fail++; $display("FAIL badhi_x_kept: got %0d want 255", x_pos); end
    if (y_pos !== 10'd16)   begin n_fail++; $display("FAIL badhi_y_kept: got %0d want 16", y_pos); end
    tick(1'b0, 8'h00);
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL badhi_err_width: got %0b want 0", frame_err); end
    send_preamble();
    send_byte(8'hFF);
    send_byte(8'h03);
    send_byte(8'hFF);
    tick(1'b1, 8'h03);
    n_checks += 3;
    if (pos_valid !== 1'b1) begin n_fail++; $display("FAIL badhi_next_valid: got %0b want 1", pos_valid); end
    if (x_pos !== 10'd1023) begin n_fail++; $display("FAIL badhi_next_x: got %0d want 1023", x_pos); end
    if (y_pos !== 10'd1023) begin n_fail++; $display("FAIL badhi_next_y: got %0d want 1023", y_pos); end
  endtask

  task automatic test_short_preamble();
    logic [7:0] seq [8];
    int seen_valid, seen_err;
    seq = '{8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h2C, 8'h01, 8'hE0, 8'h01};
    seen_valid = 0;
    seen_err   = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, seq[i]);
      seen_valid += int'(pos_valid);
      seen_err   += int'(frame_err);
      tick(1'b0, 8'h00);
      seen_valid += int'(pos_valid);
      seen_err   += int'(frame_err);
    end
    n_checks += 3;
    if (seen_valid != 0)    begin n_fail++; $display("FAIL short_valid: got %0d pulses want 0", seen_valid); end
    if (seen_err != 0)      begin n_fail++; $display("FAIL short_err: got %0d pulses want 0", seen_err); end
    if (x_pos !== 10'd1023) begin n_fail++; $display("FAIL short_x_kept: got %0d want 1023", x_pos); end
  endtask

  task automatic test_timeout();
    int early_err;
    send_preamble();
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'hAA);
    tick(1'b1, 8'h02);
    n_checks += 3;
    if (pos_valid !== 1'b1) begin n_fail++; $display("FAIL to_pre_valid: got %0b want 1", pos_valid); end
    if (x_pos !== 10'd341)  begin n_fail++; $display("FAIL to_pre_x: got %0d want 341", x_pos); end
    if (y_pos !== 10'd682)  begin n_fail++; $display("FAIL to_pre_y: got %0d want 682", y_pos); end
    send_preamble();
    tick(1'b1, 8'h2C);
    early_err = 0;
    for (int i = 1; i < TO; i++) begin
      tick(1'b0, 8'($urandom));
      early_err += int'(frame_err);
    end
    n_checks += 2;
    if (early_err != 0)     begin n_fail++; $display("FAIL to_early: got %0d pulses want 0", early_err); end
    if (sync_lock !== 1'b1) begin n_fail++; $display("FAIL to_lock_before: got %0b want 1", sync_lock); end
    tick(1'b0, 8'h00);
    n_checks += 4;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %0b want 1", frame_err); end
    if (sync_lock !== 1'b0) begin n_fail++; $display("FAIL to_lock: got %0b want 0", sync_lock); end
    if (pos_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid: got %0b want 0", pos_valid); end
    if (x_pos !== 10'd341)  begin n_fail++; $display("FAIL to_x_kept: got %0d want 341", x_pos); end
    tick(1'b0, 8'h00);
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL to_err_width: got %0b want 0", frame_err); end
    // byte landing on the expiry cycle wins, and another one just before expiry
    send_preamble();
    tick(1'b1, 8'h2C);
    early_err = 0;
    for (int i = 1; i < TO; i++) begin
      tick(1'b0, 8'h00);
      early_err += int'(frame_err);
    end
    tick(1'b1, 8'h01);
    early_err += int'(frame_err);
    for (int i = 1; i < TO - 1; i++) begin
      tick(1'b0, 8'h00);
      early_err += int'(frame_err);
    end
    tick(1'b1, 8'hE0);
    early_err += int'(frame_err);
    tick(1'b1, 8'h01);
    n_checks += 4;
    if (early_err != 0)     begin n_fail++; $display("FAIL to_edge_err: got %0d pulses want 0", early_err); end
    if (pos_valid !== 1'b1) begin n_fail++; $display("FAIL to_edge_valid: got %0b want 1", pos_valid); end
    if (x_pos !== 10'd300)  begin n_fail++; $display("FAIL to_edge_x: got %0d want 300", x_pos); end
    if (y_pos !== 10'd480)  begin n_fail++; $display("FAIL to_edge_y: got %0d want 480", y_pos); end
  endtask

  task automatic test_reset_mid_frame();
    send_preamble();
    send_byte(8'h7B);
    send_byte(8'h02);
    rst = 1'b1;
    tick(1'b1, 8'hFF);
    n_checks += 5;
    if (x_pos !== 10'd0)    begin n_fail++; $display("FAIL midrst_x: got %0d want 0", x_pos); end
    if (y_pos !== 10'd0)    begin n_fail++; $display("FAIL midrst_y: got %0d want 0", y_pos); end
    if (pos_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b want 0", pos_valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %0b want 0", frame_err); end
    if (sync_lock !== 1'b0) begin n_fail++; $display("FAIL midrst_lock: got %0b want 0", sync_lock); end
    rst = 1'b0;
    tick(1'b0, 8'h00);
    send_preamble();
    send_byte(8'h2C);
    send_byte(8'h01);
    send_byte(8'hE0);
    tick(1'b1, 8'h01);
    n_checks += 4;
    if (pos_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_after_valid: got %0b want 1", pos_valid); end
    if (x_pos !== 10'd300)  begin n_fail++; $display("FAIL midrst_after_x: got %0d want 300", x_pos); end
    if (y_pos !== 10'd480)  begin n_fail++; $display("FAIL midrst_after_y: got %0d want 480", y_pos); end
    if (sync_lock !== 1'b1) begin n_fail++; $display("FAIL midrst_after_lock: got %0b want 1", sync_lock); end
  endtask

  task automatic test_random_stream();
    logic       cyc_rd[$];
    logic [7:0] cyc_d[$];
    logic [7:0] fr[$];
    int         kind, gap, n;
    for (int c = 0; c < 80; c++) begin
      fr.delete();
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        for (int i = 0; i < SYNC_LEN; i++) fr.push_back(8'hFF);
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom_range(0, 3)));
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom_range(0, 3)));
        if (kind == 1) fr[($urandom_range(0, 1) == 0) ? 5 : 7] = 8'($urandom_range(4, 255));
      end else if (kind == 2) begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) fr.push_back(($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
      end else begin
        n = $urandom_range(0, SYNC_LEN - 1);
        for (int i = 0; i < n; i++) fr.push_back(8'hFF);
        fr.push_back(8'($urandom_range(0, 254)));
      end
      foreach (fr[i]) begin
        cyc_rd.push_back(1'b1);
        cyc_d.push_back(fr[i]);
        gap = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          cyc_rd.push_back(1'b0);
          cyc_d.push_back(8'($urandom));
        end
      end
    end
    foreach (cyc_rd[i]) begin
      tick(cyc_rd[i], cyc_d[i]);
      n_checks += 5;
      if (pos_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid @%0d: got %0b want %0b", i, pos_valid, m_valid); end
      if (frame_err !== m_err)   begin n_fail++; $display("FAIL rnd_err @%0d: got %0b want %0b", i, frame_err, m_err); end
      if (sync_lock !== m_lock)  begin n_fail++; $display("FAIL rnd_lock @%0d: got %0b want %0b", i, sync_lock, m_lock); end
      if (x_pos !== m_x)         begin n_fail++; $display("FAIL rnd_x @%0d: got %0d want %0d", i, x_pos, m_x); end
      if (y_pos !== m_y)         begin n_fail++; $display("FAIL rnd_y @%0d: got %0d want %0d", i, y_pos, m_y); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    test_reset();
    test_clean_frame();
    test_sync_as_data();
    test_bad_high_byte();
    test_short_preamble();
    test_timeout();
    test_reset_mid_frame();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
